card_dealer: RTL and testbench
==============================

# card_dealer

Card source for the blackjack game; the responder side of the player's `request`/`ready`/`cval` handshake. It holds a 52-card shoe and picks cards with a free-running LFSR. It marks dealt cards so that no card repeats until a reshuffle. Each card is presented as a blackjack value on `cval`, with ace = 11.

## Interface
- `SEED`, 8'h5A: LFSR reset value; must be nonzero.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `request`  in  1  player card request (level).
- `shuffle`  in  1  force reshuffle; sampled only in IDLE.
- `ready`  out  1  card valid on `cval`.
- `cval`  out  4  card value: 2..10, or 11 (4'b1011) for an ace.
- `cards_left`  out  6  undealt cards, 0..52.
- `reshuffled`  out  1  one-cycle pulse when the shoe is refilled.

## Operation
- All outputs are registered. Reset values:
  - `ready`=0, `cval`=0, `cards_left`=52, `reshuffled`=0.
  - Dealt mask = 0, LFSR = `SEED`, state = IDLE.
- LFSR:
  - 8-bit Galois, taps 8'hB8, advances every cycle, including during reset release.
  - Candidate = `lfsr[5:0]`; if the candidate is ≥52, subtract 52.
- Card index: idx 0..51, rank = idx>>2.
  - rank 0 → 11.
  - rank 1..9 → rank+1.
  - rank 10..12 → 10.
- FSM:
  - IDLE: `ready`=0.
    - If `shuffle` → SHUFFLE. `shuffle` has priority over `request`.
    - Else if `request` and `cards_left`==0 → SHUFFLE.
    - Else if `request` → PICK.
  - PICK: latch the candidate into idx → PROBE.
  - PROBE, when mask[idx]==0 (hit):
    - Set mask[idx] and decrement `cards_left`.
    - `cval`<=value(idx), `ready`<=1 → WAIT_DROP.
  - PROBE, when mask[idx]==1: idx <= (idx==51) ? 0 : idx+1, stay in PROBE.
  - WAIT_DROP: hold `ready`=1 with `cval` stable. When `request`==0: `ready`<=0 → IDLE.
  - SHUFFLE: mask<=0, `cards_left`<=52, `reshuffled`<=1 for one cycle → IDLE. If `request` is still high, the deal then proceeds normally.
- `cval` keeps its last value after `ready` falls.
- Protocol violation (`request` dropped before `ready`): the deal completes anyway, `ready` pulses for one cycle, and the card counts as consumed.
- `shuffle` asserted outside IDLE is ignored; it is not latched.
- Reset mid-deal: immediate return to reset values. The partially dealt shoe is lost.

## Timing
- `request` sampled high in IDLE at edge N:
  - Best case, `ready` is high after edge N+2.
  - Worst case, `ready` is high after edge N+2+51 (linear probe over a nearly full mask).
- Empty-shoe request adds 1 cycle for SHUFFLE.
- `ready` falls 1 cycle after `request` is sampled low.
- The next request is accepted no earlier than the cycle after returning to IDLE.
- The player sees a four-phase handshake: request↑, ready↑, request↓, ready↓.

## Configuration
- `CARD_DEALER_INFINITE_EN` defined: infinite shoe.
  - No dealt mask; PROBE always hits.
  - `cards_left` is constant 52; no automatic reshuffle.
  - `shuffle` only produces the `reshuffled` pulse.
- Undefined: finite 52-card shoe with depletion and auto-reshuffle, as described in Operation.

## Structure
- Shared package `blackjack_pkg` holds:
  - `CARD_ACE_VAL`=4'd11, `DECK_SIZE`=52.
  - `LFSR_TAPS`=8'hB8.
  - The dealer state enum.
  - The function mapping idx to value.
- Sub-module `dealer_lfsr`: parameterised seed, outputs the 8-bit state.
- The existing `seg_driver` may display `cval` at top level; it is not instantiated inside this block.

## Test plan
- Reset, then hold `request` low for 10 cycles → `ready`=0, `cards_left`=52, `cval`=0, `reshuffled`=0.
- 52 handshaked draws → values:
  - exactly 4 each of 2..9 and 11;
  - 16 tens;
  - sum = 380;
  - `cards_left` reaches 0;
  - no duplicate idx.
- 53rd request → `reshuffled` pulse, `ready` within 3..54 cycles, `cards_left`=51.
- `shuffle` pulsed in IDLE after 10 draws → `reshuffled`=1 for one cycle, `cards_left`=52. `shuffle` pulsed in WAIT_DROP → no effect.
- Hold `request` high after `ready` for 20 cycles → `ready` and `cval` stay stable. Drop `request` → `ready`=0 one cycle later.
- Assert `rst` during PROBE → `ready`=0 and `cards_left`=52 immediately. The next draw completes normally.

Source files
------------

// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared card constants, dealer state type and card index to value mapping.
package blackjack_pkg;
  localparam logic [3:0] CARD_ACE_VAL = 4'd11;
  localparam logic [5:0] DECK_SIZE = 6'd52;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [2:0] {IDLE, PICK, PROBE, WAIT_DROP, SHUFFLE} dealer_state_t;
  function automatic logic [3:0] card_value(input logic [5:0] idx);
    return (idx >> 2) == 6'd0 ? CARD_ACE_VAL : (idx >> 2) >= 6'd10 ? 4'd10 : 4'((idx >> 2) + 6'd1);
  endfunction
endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: player/dealer four-phase card handshake plus shoe status.
interface card_dealer_if;
  logic request;
  logic shuffle;
  logic ready;
  logic reshuffled;
  logic [3:0] cval;
  logic [5:0] cards_left;
  modport master (output request, shuffle, input ready, cval, cards_left, reshuffled);
  modport slave (input request, shuffle, output ready, cval, cards_left, reshuffled);
endinterface

// File: rtl/dealer_lfsr.sv
// dealer_lfsr: free-running 8-bit Galois LFSR used to pick candidate cards.
module dealer_lfsr import blackjack_pkg::*; #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_state
);
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_lfsr <= SEED;
    else r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
  assign o_state = r_lfsr;
endmodule

// File: rtl/card_dealer.sv
// card_dealer: 52-card shoe dealer answering the player's request/ready handshake.
// Define CARD_DEALER_INFINITE_EN for an infinite shoe (no dealt mask, no depletion).
module card_dealer import blackjack_pkg::*; #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input logic        clk,
  input logic        rst,
  card_dealer_if.slave io_bus
);
  logic [7:0] w_lfsr;
  logic [5:0] w_cand;
  logic w_hit;
  logic w_empty;
  logic w_unused;
  dealer_state_t r_state;
  logic [5:0] r_idx;
  logic r_ready;
  logic r_reshuffled;
  logic [3:0] r_cval;
  dealer_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .o_state(w_lfsr));
  assign w_cand = w_lfsr[5:0] >= DECK_SIZE ? w_lfsr[5:0] - DECK_SIZE : w_lfsr[5:0];
  assign w_unused = ^w_lfsr[7:6];
`ifdef CARD_DEALER_INFINITE_EN
  assign w_hit = 1'b1;
  assign w_empty = 1'b0;
  assign io_bus.cards_left = DECK_SIZE;
`else
  logic [DECK_SIZE-1:0] r_mask;
  logic [5:0] r_cards_left;
  assign w_hit = !r_mask[r_idx];
  assign w_empty = r_cards_left == 6'd0;
  assign io_bus.cards_left = r_cards_left;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mask <= '0;
      r_cards_left <= DECK_SIZE;
    end else if (r_state == SHUFFLE) begin
      r_mask <= '0;
      r_cards_left <= DECK_SIZE;
    end else if (r_state == PROBE && w_hit) begin
      r_mask[r_idx] <= 1'b1;
      r_cards_left <= r_cards_left - 6'd1;
    end
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_ready <= 1'b0;
      r_cval <= '0;
      r_reshuffled <= 1'b0;
    end else begin
      r_reshuffled <= 1'b0;
      case (r_state)
        IDLE: r_state <= io_bus.shuffle ? SHUFFLE : !io_bus.request ? IDLE : w_empty ? SHUFFLE : PICK;
        PICK: begin
          r_idx <= w_cand;
          r_state <= PROBE;
        end
        PROBE:
          if (w_hit) begin
            r_cval <= card_value(r_idx);
            r_ready <= 1'b1;
            r_state <= WAIT_DROP;
          end else r_idx <= r_idx == DECK_SIZE - 6'd1 ? 6'd0 : r_idx + 6'd1;
        WAIT_DROP:
          if (!io_bus.request) begin
            r_ready <= 1'b0;
            r_state <= IDLE;
          end
        SHUFFLE: begin
          r_reshuffled <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign io_bus.ready = r_ready;
  assign io_bus.cval = r_cval;
  assign io_bus.reshuffled = r_reshuffled;
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed stimulus with a transaction-level shoe model checked every cycle.
module tb_card_dealer;
  logic clk;
  logic rst;
  logic chk_en;
  int n_chk, n_err, n_resh;
  int cnt [12];
  card_dealer_if bus();
  card_dealer #(.SEED(8'h5A)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Shoe model: a deal is resolved in one step (candidate, linear probe count) and
  // then released after the resulting latency.
  logic [7:0] m_lfsr;
  bit m_mask [52];
  int m_left, m_ph, m_cnt, m_idx;
  logic e_ready, e_resh;
  logic [3:0] e_cval;

  function automatic logic [7:0] adv(input logic [7:0] s);
    return s[0] ? (s >> 1) ^ 8'hB8 : s >> 1;
  endfunction
  function automatic int cand_of(input logic [7:0] s);
    int c = int'(s) % 64;
    return c >= 52 ? c - 52 : c;
  endfunction
  function automatic int probes(input int c);
    int k = 0;
    while (k < 52 && m_mask[(c + k) % 52]) k++;
    return k;
  endfunction
  function automatic int val_of(input int idx);
    int r = idx / 4;
    return r == 0 ? 11 : (r > 9 ? 10 : r + 1);
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_lfsr <= 8'h5A;
      m_mask <= '{default: 1'b0};
      m_left <= 52;
      m_ph <= 0;
      m_cnt <= 0;
      m_idx <= 0;
      e_ready <= 1'b0;
      e_resh <= 1'b0;
      e_cval <= 4'd0;
    end else begin
      m_lfsr <= adv(m_lfsr);
      e_resh <= 1'b0;
      if (m_ph == 0 && (bus.shuffle || (bus.request && m_left == 0))) m_ph <= 3;
      else if (m_ph == 0 && bus.request) begin
        m_idx <= (cand_of(adv(m_lfsr)) + probes(cand_of(adv(m_lfsr)))) % 52;
        m_cnt <= 2 + probes(cand_of(adv(m_lfsr)));
        m_ph <= 1;
      end else if (m_ph == 1 && m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (m_ph == 1) begin
        m_mask[m_idx] <= 1'b1;
        m_left <= m_left - 1;
        e_cval <= 4'(val_of(m_idx));
        e_ready <= 1'b1;
        m_ph <= 2;
      end else if (m_ph == 2 && !bus.request) begin
        e_ready <= 1'b0;
        m_ph <= 0;
      end else if (m_ph == 3) begin
        m_mask <= '{default: 1'b0};
        m_left <= 52;
        e_resh <= 1'b1;
        m_ph <= 0;
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("model_ready", int'(bus.ready), int'(e_ready));
      chk("model_cval", int'(bus.cval), int'(e_cval));
      chk("model_left", int'(bus.cards_left), m_left);
      chk("model_resh", int'(bus.reshuffled), int'(e_resh));
      if (bus.reshuffled) n_resh++;
    end

  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ready && lat < 60);
    chk("ready_rise", int'(bus.ready), 1);
  endtask

  task automatic draw(input string n, output int v);
    int lat;
    bus.request = 1'b1;
    wait_ready(lat);
    chk({n, "_lat_ok"}, int'(lat >= 3 && lat <= 54), 1);
    v = int'(bus.cval);
    bus.request = 1'b0;
    @(negedge clk);
    chk({n, "_ready_fall"}, int'(bus.ready), 0);
  endtask

  initial begin
    int v, sum, lat, r0;
    n_chk = 0;
    n_err = 0;
    n_resh = 0;
    sum = 0;
    cnt = '{default: 0};
    chk_en = 1'b0;
    bus.request = 1'b0;
    bus.shuffle = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_left", int'(bus.cards_left), 52);
    chk("rst_cval", int'(bus.cval), 0);
    chk("rst_resh", int'(bus.reshuffled), 0);
    for (int i = 0; i < 52; i++) begin
      draw("deal", v);
      sum += v;
      if (v >= 0 && v < 12) cnt[v]++;
    end
    chk("sum52", sum, 380);
    chk("left_empty", int'(bus.cards_left), 0);
    for (int k = 2; k < 12; k++) chk($sformatf("count_%0d", k), cnt[k], k == 10 ? 16 : 4);
    r0 = n_resh;
    bus.request = 1'b1;
    wait_ready(lat);
    chk("lat53", int'(lat >= 3 && lat <= 54), 1);
    chk("resh53", n_resh - r0, 1);
    chk("left53", int'(bus.cards_left), 51);
    bus.request = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) draw("deal10", v);
    chk("left_after10", int'(bus.cards_left), 42);
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    chk("shuf_pre", int'(bus.reshuffled), 0);
    @(negedge clk);
    chk("shuf_pulse", int'(bus.reshuffled), 1);
    chk("shuf_left", int'(bus.cards_left), 52);
    @(negedge clk);
    chk("shuf_end", int'(bus.reshuffled), 0);
    r0 = n_resh;
    bus.request = 1'b1;
    wait_ready(lat);
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_ready", int'(bus.ready), 1);
    end
    chk("wd_shuf_left", int'(bus.cards_left), 51);
    chk("wd_shuf_resh", n_resh - r0, 0);
    bus.request = 1'b0;
    @(negedge clk);
    chk("drop_ready", int'(bus.ready), 0);
    bus.request = 1'b1;
    @(negedge clk);
    bus.request = 1'b0;
    wait_ready(lat);
    @(negedge clk);
    chk("viol_pulse_end", int'(bus.ready), 0);
    chk("viol_left", int'(bus.cards_left), 50);
    bus.request = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.request = 1'b0;
    #1;
    chk("probe_rst_ready", int'(bus.ready), 0);
    chk("probe_rst_left", int'(bus.cards_left), 52);
    @(negedge clk);
    rst = 1'b1;
    draw("post_rst", v);
    chk("post_rst_left", int'(bus.cards_left), 51);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
